// File: rtl/riscv_upg_loader_pkg.sv
// Shared constants and encodings for the UART programmer frame loader.
package riscv_upg_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ERR_W  = 2;

  localparam logic [BYTE_W-1:0] UPG_SYNC = 8'hA5;
  localparam logic [BYTE_W-1:0] UPG_TGT_MAX = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TGT,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } upg_state_e;

  typedef enum logic [ERR_W-1:0] {
    UPG_ERR_NONE = 2'b00,
    UPG_ERR_CSUM = 2'b01,
    UPG_ERR_TMO  = 2'b10,
    UPG_ERR_HDR  = 2'b11
  } upg_err_e;

endpackage

// File: rtl/riscv_upg_loader_if.sv
// Byte-in / memory-write-out bundle between the UART receiver, the loader and the memories.
interface riscv_upg_loader_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              rx_valid_i;
  logic [7:0]        rx_data_i;
  logic              upg_wen_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [31:0]       upg_dat_o;
  logic              upg_sel_o;
  logic              upg_done_o;
  logic              upg_busy_o;
  logic [1:0]        upg_err_o;

  // Byte source / memory side
  modport master (
    output rx_valid_i, rx_data_i,
    input  upg_wen_o, upg_adr_o, upg_dat_o, upg_sel_o, upg_done_o, upg_busy_o, upg_err_o
  );

  // Loader side
  modport slave (
    input  rx_valid_i, rx_data_i,
    output upg_wen_o, upg_adr_o, upg_dat_o, upg_sel_o, upg_done_o, upg_busy_o, upg_err_o
  );
endinterface

// File: rtl/riscv_upg_loader_word_asm.sv
// Little-endian byte-to-word assembler; the completed word is presented combinationally
// in the same cycle as its 4th byte so the caller can register the write strobe directly.
module riscv_upg_loader_word_asm
  import riscv_upg_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              byte_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_valid_c_o,
  output logic [WORD_W-1:0] word_c_o
);
  localparam int unsigned LOW_W = WORD_W - BYTE_W;

  logic [1:0]       byte_cnt_q;
  logic [LOW_W-1:0] shreg_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      byte_cnt_q <= 2'd0;
      shreg_q    <= '0;
    end else if (byte_en_i) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
      shreg_q    <= {byte_i, shreg_q[LOW_W-1:BYTE_W]};
    end
  end

  assign word_valid_c_o = byte_en_i && !clr_i && (byte_cnt_q == 2'd3);
  assign word_c_o       = {byte_i, shreg_q};

endmodule

// File: rtl/riscv_upg_loader.sv
// UART programmer frame decoder: parses SYNC/TGT/CNT/data/CSUM frames and issues one
// memory write per reassembled 32-bit word, flagging checksum, timeout and header errors.
module riscv_upg_loader
  import riscv_upg_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned TIMEOUT = 1000000
) (
  input logic               clk,
  input logic               rst,
  riscv_upg_loader_if.slave bus
);
  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [31:0] N_MAX = 32'd1 << ADDR_W;

  upg_state_e        state_q;
  upg_err_e          err_q;
  logic              wen_q;
  logic [ADDR_W-1:0] adr_q;
  logic [ADDR_W-1:0] widx_q;
  logic [WORD_W-1:0] dat_q;
  logic              sel_q;
  logic              done_q;
  logic              busy_q;
  logic [15:0]       n_q;
  logic [BYTE_W-1:0] csum_q;
  logic [TMO_W-1:0]  tmo_q;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic [15:0]       n_hdr_c;
  logic              n_too_big_c;
  logic              last_word_c;
  logic              word_valid_c;
  logic [WORD_W-1:0] word_c;

  assign rx_valid    = bus.rx_valid_i;
  assign rx_data     = bus.rx_data_i;
  assign n_hdr_c     = {rx_data, n_q[7:0]};
  assign n_too_big_c = 32'(n_hdr_c) > N_MAX;
  assign last_word_c = (IDX_W'(widx_q) + IDX_W'(1)) == IDX_W'(n_q);

  // Assembler is held clear outside DATA so an aborted frame never leaves a partial word
  riscv_upg_loader_word_asm u_word_asm (
    .clk            (clk),
    .rst            (rst),
    .clr_i          (state_q != ST_DATA),
    .byte_en_i      (rx_valid),
    .byte_i         (rx_data),
    .word_valid_c_o (word_valid_c),
    .word_c_o       (word_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= UPG_ERR_NONE;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      widx_q  <= '0;
      dat_q   <= '0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      n_q     <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
    end else begin
      wen_q <= 1'b0;

      // Idle-gap counter only runs while a frame is open; a byte always restarts it
      if (rx_valid || !busy_q || (tmo_q == TMO_LAST)) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end

      if (rx_valid) begin
        case (state_q)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (rx_data == UPG_SYNC) begin
              state_q <= ST_TGT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              err_q   <= UPG_ERR_NONE;
              csum_q  <= '0;
            end
          end
          ST_TGT: begin
            csum_q <= csum_q ^ rx_data;
            if (rx_data > UPG_TGT_MAX) begin
              state_q <= ST_ERR;
              err_q   <= UPG_ERR_HDR;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_CNT_LO;
              sel_q   <= rx_data[0];
            end
          end
          ST_CNT_LO: begin
            csum_q  <= csum_q ^ rx_data;
            n_q     <= {8'h00, rx_data};
            state_q <= ST_CNT_HI;
          end
          ST_CNT_HI: begin
            csum_q <= csum_q ^ rx_data;
            n_q    <= n_hdr_c;
            widx_q <= '0;
            if (n_too_big_c) begin
              state_q <= ST_ERR;
              err_q   <= UPG_ERR_HDR;
              busy_q  <= 1'b0;
            end else if (n_hdr_c == 16'd0) begin
              state_q <= ST_CSUM;
            end else begin
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            csum_q <= csum_q ^ rx_data;
            if (word_valid_c) begin
              wen_q  <= 1'b1;
              adr_q  <= widx_q;
              dat_q  <= word_c;
              widx_q <= widx_q + ADDR_W'(1);
              if (last_word_c) begin
                state_q <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            busy_q <= 1'b0;
            if (rx_data == csum_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ERR;
              err_q   <= UPG_ERR_CSUM;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (busy_q && (tmo_q == TMO_LAST)) begin
        state_q <= ST_ERR;
        err_q   <= UPG_ERR_TMO;
        busy_q  <= 1'b0;
      end
    end
  end

  assign bus.upg_wen_o  = wen_q;
  assign bus.upg_adr_o  = adr_q;
  assign bus.upg_dat_o  = dat_q;
  assign bus.upg_sel_o  = sel_q;
  assign bus.upg_done_o = done_q;
  assign bus.upg_busy_o = busy_q;
  assign bus.upg_err_o  = err_q;

endmodule

// File: tb/tb_riscv_upg_loader.sv
// Directed bench for riscv_upg_loader: good frames, checksum/timeout/header errors, reset, back-to-back bytes.
module tb_riscv_upg_loader;
  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned TIMEOUT = 16;

  // Case-1 frame. XOR of 01 02 00 11 22 33 44 55 66 77 88 = 0x8B.
  localparam logic [103:0] C1_OK  = {8'hA5, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33,
                                     8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h8B};
  localparam logic [103:0] C1_BAD = {8'hA5, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33,
                                     8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h04};

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  wr_t  wr_q[$];

  always #5 clk = ~clk;

  riscv_upg_loader_if #(.ADDR_W(ADDR_W)) bus ();

  riscv_upg_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Write log, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst && bus.upg_wen_o) wr_q.push_back({bus.upg_adr_o, bus.upg_dat_o});
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tx(input logic [7:0] b);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    @(posedge clk);
    #1;
    bus.rx_valid_i = 1'b0;
  endtask

  // First byte of the frame is the most significant of the len bytes
  task automatic frame(input logic [127:0] fr, input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      tx(fr[8*(len-1-i) +: 8]);
      idle(gap);
    end
  endtask

  task automatic expect_wr(input string tag, input logic [ADDR_W-1:0] adr, input logic [31:0] dat);
    wr_t w;
    if (wr_q.size() == 0) begin
      chk({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      w = wr_q.pop_front();
      chk({tag, "_adr"}, 64'(w.adr), 64'(adr));
      chk({tag, "_dat"}, 64'(w.dat), 64'(dat));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wen"},  64'(bus.upg_wen_o),  64'd0);
    chk({tag, "_adr"},  64'(bus.upg_adr_o),  64'd0);
    chk({tag, "_dat"},  64'(bus.upg_dat_o),  64'd0);
    chk({tag, "_sel"},  64'(bus.upg_sel_o),  64'd0);
    chk({tag, "_done"}, 64'(bus.upg_done_o), 64'd0);
    chk({tag, "_busy"}, 64'(bus.upg_busy_o), 64'd0);
    chk({tag, "_err"},  64'(bus.upg_err_o),  64'd0);
  endtask

  task automatic chk_case1(input string tag);
    chk({tag, "_nwr"},  64'(wr_q.size()),    64'd2);
    expect_wr({tag, "_w0"}, 14'd0, 32'h4433_2211);
    expect_wr({tag, "_w1"}, 14'd1, 32'h8877_6655);
    chk({tag, "_sel"},  64'(bus.upg_sel_o),  64'd1);
    chk({tag, "_done"}, 64'(bus.upg_done_o), 64'd1);
    chk({tag, "_err"},  64'(bus.upg_err_o),  64'd0);
    chk({tag, "_busy"}, 64'(bus.upg_busy_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    chk_all_zero("reset");

    // Non-sync bytes in IDLE are ignored
    tx(8'h00);
    tx(8'h55);
    idle(2);
    chk("idle_busy", 64'(bus.upg_busy_o), 64'd0);

    // Case 1, byte by byte to check strobe and done latency
    tx(8'hA5); idle(1);
    chk("c1_busy", 64'(bus.upg_busy_o), 64'd1);
    tx(8'h01); idle(1); tx(8'h02); idle(1); tx(8'h00); idle(1);
    tx(8'h11); idle(1); tx(8'h22); idle(1); tx(8'h33); idle(1);
    chk("c1_no_early_wen", 64'(bus.upg_wen_o), 64'd0);
    tx(8'h44);
    chk("c1_wen_lat", 64'(bus.upg_wen_o), 64'd1);
    chk("c1_wen_dat", 64'(bus.upg_dat_o), 64'h4433_2211);
    idle(1);
    chk("c1_wen_pulse", 64'(bus.upg_wen_o), 64'd0);
    chk("c1_dat_hold",  64'(bus.upg_dat_o), 64'h4433_2211);
    tx(8'h55); idle(1); tx(8'h66); idle(1); tx(8'h77); idle(1); tx(8'h88); idle(1);
    chk("c1_busy_csum", 64'(bus.upg_busy_o), 64'd1);
    chk("c1_done_early", 64'(bus.upg_done_o), 64'd0);
    tx(8'h8B);
    chk("c1_done_lat", 64'(bus.upg_done_o), 64'd1);
    idle(1);
    chk_case1("c1");

    // Case 2: bad checksum, writes stay issued, next SYNC clears the error
    frame(128'(C1_BAD), 13, 1);
    chk("c2_nwr", 64'(wr_q.size()), 64'd2);
    expect_wr("c2_w0", 14'd0, 32'h4433_2211);
    expect_wr("c2_w1", 14'd1, 32'h8877_6655);
    chk("c2_done", 64'(bus.upg_done_o), 64'd0);
    chk("c2_err",  64'(bus.upg_err_o),  64'd1);
    tx(8'hA5);
    chk("c2_err_clr", 64'(bus.upg_err_o),  64'd0);
    chk("c2_busy",    64'(bus.upg_busy_o), 64'd1);

    // Case 3: continue that frame as N=0 to instruction memory
    frame(128'({8'h00, 8'h00, 8'h00, 8'h00}), 4, 1);
    chk("c3_nwr",  64'(wr_q.size()),    64'd0);
    chk("c3_done", 64'(bus.upg_done_o), 64'd1);
    chk("c3_sel",  64'(bus.upg_sel_o),  64'd0);
    chk("c3_err",  64'(bus.upg_err_o),  64'd0);
    tx(8'h12); idle(1);
    chk("c3_done_sticky", 64'(bus.upg_done_o), 64'd1);

    // Case 4: silence after 2 data bytes
    frame(128'({8'hA5, 8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD}), 6, 0);
    chk("c4_done_clr", 64'(bus.upg_done_o), 64'd0);
    idle(TIMEOUT - 1);
    chk("c4_err_early", 64'(bus.upg_err_o),  64'd0);
    chk("c4_busy_wait", 64'(bus.upg_busy_o), 64'd1);
    idle(1);
    chk("c4_err_tmo", 64'(bus.upg_err_o),  64'd2);
    chk("c4_busy",    64'(bus.upg_busy_o), 64'd0);
    chk("c4_nwr",     64'(wr_q.size()),    64'd0);

    // Case 5: bad target, then N one above capacity
    frame(128'({8'hA5, 8'h02}), 2, 1);
    chk("c5a_err",  64'(bus.upg_err_o),  64'd3);
    chk("c5a_busy", 64'(bus.upg_busy_o), 64'd0);
    frame(128'({8'hA5, 8'h00, 8'h01, 8'h40}), 4, 1);
    chk("c5b_err",  64'(bus.upg_err_o),  64'd3);
    chk("c5b_busy", 64'(bus.upg_busy_o), 64'd0);
    frame(128'({8'hAA, 8'hBB, 8'hCC, 8'hDD}), 4, 1);
    chk("c5_nwr",   64'(wr_q.size()),    64'd0);

    // Case 6: reset mid-DATA, then a gapped frame and a back-to-back frame
    frame(128'({8'hA5, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22}), 6, 1);
    chk("c6_sel_pre", 64'(bus.upg_sel_o), 64'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_all_zero("c6_rst");
    chk("c6_rst_nwr", 64'(wr_q.size()), 64'd0);
    frame(128'(C1_OK), 13, 1);
    chk_case1("c6_gap");
    frame(128'(C1_OK), 13, 0);
    idle(1);
    chk_case1("c6_b2b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
